// File: rtl/nios2_oci_trace_capture.sv
// Trace capture front end: unpacks multi-frame DCT beats into a FIFO,
// exposes the FIFO through a valid/ready read port and tracks the test
// lifecycle (run, drain, done) along with frame and error statistics.
module nios2_oci_trace_capture #(
    parameter int FRAME_W = 10,
    parameter int LANES   = 3,
    parameter int CNT_W   = 4,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       dct_valid,
    output logic                       dct_ready,
    input  logic [FRAME_W*LANES-1:0]   dct_buffer,
    input  logic [CNT_W-1:0]           dct_count,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [FRAME_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [31:0]                frame_total,
    output logic                       bad_count,
    output logic [1:0]                 state,
    output logic                       done
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int REM_W  = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     cur_state, nxt_state;
    logic [FRAME_W*LANES-1:0]   beat_buf;
    logic [REM_W-1:0]           rem;
    logic [REM_W-1:0]           lane;
    logic [FRAME_W-1:0]         mem [DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [FILL_W-1:0]          fill;
    logic [FRAME_W-1:0]         last_data;
    logic [FRAME_W-1:0]         cur_frame;
    logic [31:0]                total;
    logic                       bad;
    logic                       accept, push, pop, flush, start;

    // Handshakes are derived only from registered state, so dct_ready never
    // depends combinationally on dct_valid.
    assign dct_ready   = (cur_state == RUN) && (rem == '0);
    assign accept      = dct_valid && dct_ready;
    assign rd_valid    = (fill != '0);
    assign pop         = rd_valid && rd_ready;
    assign push        = (rem != '0) && ((fill < FILL_W'(DEPTH)) || pop);
    assign flush       = !enable;
    assign start       = (cur_state == IDLE) && enable;
    assign cur_frame   = beat_buf[int'(lane)*FRAME_W +: FRAME_W];

    // When empty the read port keeps showing the most recently popped frame.
    assign rd_data     = rd_valid ? mem[rd_ptr] : last_data;
    assign fill_level  = fill;
    assign frame_total = total;
    assign bad_count   = bad;
    assign state       = cur_state;
    assign done        = (cur_state == DONE);

    // Lifecycle state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_state <= IDLE;
        else          cur_state <= nxt_state;
    end

    // Lifecycle transitions; dropping enable overrides everything else.
    always_comb begin
        nxt_state = cur_state;
        if (!enable) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:    nxt_state = RUN;
                RUN:     if (test_ending || test_has_ended) nxt_state = DRAIN;
                DRAIN:   if (test_has_ended && (rem == '0) && (fill == '0)) nxt_state = DONE;
                DONE:    nxt_state = DONE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Unpacker: latches a beat and walks its lanes one per FIFO write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_buf <= '0;
            rem      <= '0;
            lane     <= '0;
        end else if (flush) begin
            rem      <= '0;
            lane     <= '0;
        end else if (accept) begin
            beat_buf <= dct_buffer;
            lane     <= '0;
            rem      <= (dct_count > CNT_W'(LANES)) ? REM_W'(LANES) : REM_W'(dct_count);
        end else if (push) begin
            lane     <= lane + REM_W'(1);
            rem      <= rem - REM_W'(1);
        end
    end

    // FIFO storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= cur_frame;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            last_data <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Session statistics: cleared when a session starts, held while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total <= '0;
            bad   <= 1'b0;
        end else if (start) begin
            total <= '0;
            bad   <= 1'b0;
        end else if (!flush) begin
            if (push && (total != '1)) total <= total + 32'd1;
            if (accept && (dct_count > CNT_W'(LANES))) bad <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed bench for the trace capture block: expected frames go into a
// scoreboard queue when beats are driven and are checked as they are popped.
module tb_nios2_oci_trace_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        dct_valid;
    logic        dct_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_valid;
    logic        rd_ready;
    logic [9:0]  rd_data;
    logic [4:0]  fill_level;
    logic [31:0] frame_total;
    logic        bad_count;
    logic [1:0]  state;
    logic        done;

    int          compared   = 0;
    int          mismatched = 0;
    logic        last_accept;
    logic [9:0]  sb [$];

    nios2_oci_trace_capture dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .fill_level     (fill_level),
        .frame_total    (frame_total),
        .bad_count      (bad_count),
        .state          (state),
        .done           (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check any pop against the scoreboard, note acceptance, advance.
    task automatic step();
        logic [9:0] exp;
        #1;
        if (rd_valid && rd_ready) begin
            checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(exp));
            end
        end
        last_accept = dct_valid && dct_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a beat until accepted, queuing the frames it should produce.
    task automatic applyStimulus(input logic [29:0] beat, input logic [3:0] cnt);
        logic [29:0] b;
        int          n;
        logic        got;
        b          = beat;
        n          = (cnt > 4'd3) ? 3 : int'(cnt);
        dct_buffer = beat;
        dct_count  = cnt;
        dct_valid  = 1'b1;
        for (int i = 0; i < n; i++) sb.push_back(b[i*10 +: 10]);
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            step();
            got = last_accept;
        end
        dct_valid = 1'b0;
        checkOutput("beat_accepted", 32'(got), 32'd1);
    endtask

    task automatic drainAll();
        for (int k = 0; k < 100 && rd_valid; k++) step();
        checkOutput("drain_done", 32'(rd_valid), 32'd0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b0;
        dct_valid      = 1'b0;
        dct_buffer     = '0;
        dct_count      = '0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_ready       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_dct_ready", 32'(dct_ready), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_fill", 32'(fill_level), 32'd0);
        checkOutput("rst_total", frame_total, 32'd0);
        checkOutput("rst_bad", 32'(bad_count), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(negedge clk);

        reset_n = 1'b1;
        enable  = 1'b1;
        step();
        checkOutput("run_state", 32'(state), 32'd1);
        checkOutput("run_ready", 32'(dct_ready), 32'd1);

        $display("[TB] single beat, streaming read");
        rd_ready = 1'b1;
        applyStimulus({10'h3FF, 10'h155, 10'h0AA}, 4'd3);
        #1;
        checkOutput("no_bypass", 32'(rd_valid), 32'd0);
        checkOutput("busy_ready", 32'(dct_ready), 32'd0);
        step();
        checkOutput("first_head", 32'(rd_data), 32'h0AA);
        step();
        step();
        checkOutput("ready_after_3", 32'(dct_ready), 32'd1);
        step();
        checkOutput("t1_total", frame_total, 32'd3);
        checkOutput("t1_fill", 32'(fill_level), 32'd0);
        checkOutput("t1_hold_data", 32'(rd_data), 32'h3FF);

        $display("[TB] restart session, fill FIFO to full");
        enable = 1'b0;
        step();
        checkOutput("idle_state", 32'(state), 32'd0);
        enable = 1'b1;
        step();
        checkOutput("restart_total", frame_total, 32'd0);
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(30'($urandom), 4'd3);
        step();
        step();
        step();
        checkOutput("full_fill", 32'(fill_level), 32'd16);
        checkOutput("full_ready", 32'(dct_ready), 32'd0);
        checkOutput("full_total", frame_total, 32'd16);
        rd_ready = 1'b1;
        step();
        checkOutput("pushpop_fill", 32'(fill_level), 32'd16);
        drainAll();
        checkOutput("t2_total", frame_total, 32'd18);

        $display("[TB] zero and oversize counts");
        applyStimulus(30'h1234_5678, 4'd0);
        #1;
        checkOutput("zero_ready", 32'(dct_ready), 32'd1);
        step();
        checkOutput("zero_fill", 32'(fill_level), 32'd0);
        checkOutput("zero_total", frame_total, 32'd18);
        applyStimulus({10'h201, 10'h0F0, 10'h00F}, 4'd7);
        #1;
        checkOutput("bad_set", 32'(bad_count), 32'd1);
        for (int i = 0; i < 5; i++) step();
        checkOutput("t3_total", frame_total, 32'd21);
        checkOutput("bad_sticky", 32'(bad_count), 32'd1);
        checkOutput("t3_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] drain and done");
        rd_ready = 1'b0;
        applyStimulus({10'h111, 10'h222, 10'h333}, 4'd3);
        applyStimulus({10'h000, 10'h2AA, 10'h155}, 4'd2);
        step();
        step();
        checkOutput("drain_fill", 32'(fill_level), 32'd5);
        test_ending = 1'b1;
        step();
        checkOutput("drain_state", 32'(state), 32'd2);
        checkOutput("drain_ready", 32'(dct_ready), 32'd0);
        test_has_ended = 1'b1;
        rd_ready       = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checkOutput("drain_empty", 32'(fill_level), 32'd0);
        checkOutput("still_drain", 32'(state), 32'd2);
        step();
        checkOutput("done_state", 32'(state), 32'd3);
        checkOutput("done_flag", 32'(done), 32'd1);
        enable         = 1'b0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        step();
        checkOutput("off_state", 32'(state), 32'd0);
        checkOutput("off_done", 32'(done), 32'd0);
        checkOutput("off_bad_hold", 32'(bad_count), 32'd1);
        checkOutput("off_total_hold", frame_total, 32'd26);

        $display("[TB] reset mid-unpack");
        enable = 1'b1;
        step();
        checkOutput("s3_total", frame_total, 32'd0);
        checkOutput("s3_bad", 32'(bad_count), 32'd0);
        rd_ready = 1'b0;
        applyStimulus({10'h0C3, 10'h3C0, 10'h03C}, 4'd3);
        step();
        checkOutput("mid_fill", 32'(fill_level), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mr_dct_ready", 32'(dct_ready), 32'd0);
        checkOutput("mr_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("mr_rd_data", 32'(rd_data), 32'd0);
        checkOutput("mr_fill", 32'(fill_level), 32'd0);
        checkOutput("mr_total", frame_total, 32'd0);
        checkOutput("mr_state", 32'(state), 32'd0);
        checkOutput("mr_done", 32'(done), 32'd0);
        sb.delete();
        step();
        reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
